// File: rtl/ext_segment_scan_if.sv
// Level load strobe, conversion status and segment/digit drive grouped as one bundle.
// master = game-side driver of level/level_valid; slave = the scanner.
interface ext_segment_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int LEVEL_W    = 4
);
  logic [LEVEL_W-1:0]    level;
  logic                  level_valid;
  logic [7:0]            seg_bits;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  busy;

  modport master (
    output level, level_valid,
    input  seg_bits, digit_sel, busy
  );

  modport slave (
    input  level, level_valid,
    output seg_bits, digit_sel, busy
  );
endinterface

// File: rtl/ext_segment_scan.sv
// Multiplexed segment scanner: double-dabble level conversion, tier glyph on the top digit.
// Optional blink-on-change enabled by defining EXT_SEG_BLINK_EN.
module ext_segment_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int LEVEL_W      = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLINK_FRAMES = 3
) (
  input logic               clock,
  input logic               reset_n,
  ext_segment_scan_if.slave bus
);

  localparam int BCD_W = 4 * (NUM_DIGITS - 1);
  localparam int PW    = $clog2(CLK_DIV);
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam int CW    = $clog2(LEVEL_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state, state_nxt;
  logic [LEVEL_W-1:0] bin_sr, conv_level, pend_level, load_val;
  logic [BCD_W-1:0]   bcd_sr;
  logic [CW-1:0]      shift_cnt;
  logic               pend_vld, load_new;
  logic [7:0]         disp [NUM_DIGITS];
  logic [7:0]         commit_disp [NUM_DIGITS];
  logic [PW-1:0]      presc;
  logic [IW-1:0]      scan_idx;
  logic               tick, blank_now;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+LEVEL_W-1:0] dd;
  logic               seen;

  function automatic logic [7:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0: dec_glyph = 8'h3F;
      4'd1: dec_glyph = 8'h06;
      4'd2: dec_glyph = 8'h5B;
      4'd3: dec_glyph = 8'h4F;
      4'd4: dec_glyph = 8'h66;
      4'd5: dec_glyph = 8'h6D;
      4'd6: dec_glyph = 8'h7D;
      4'd7: dec_glyph = 8'h07;
      4'd8: dec_glyph = 8'h7F;
      4'd9: dec_glyph = 8'h6F;
      default: dec_glyph = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] tier_glyph(input logic [LEVEL_W-1:0] lv);
    int unsigned v;
    v = 32'(lv);
    if (v <= 3)      tier_glyph = 8'h0B;
    else if (v <= 5) tier_glyph = 8'hBD;
    else if (v <= 7) tier_glyph = 8'h9F;
    else             tier_glyph = 8'h08;
  endfunction

  // A strobe landing in COMMIT is the newest value, so it outranks the pending register.
  always_comb begin
    state_nxt = state;
    load_new  = 1'b0;
    load_val  = bus.level;
    case (state)
      IDLE: if (bus.level_valid) begin
        state_nxt = SHIFT;
        load_new  = 1'b1;
      end
      SHIFT: if (shift_cnt == CW'(LEVEL_W - 1)) state_nxt = COMMIT;
      COMMIT: begin
        state_nxt = IDLE;
        if (bus.level_valid) begin
          state_nxt = SHIFT;
          load_new  = 1'b1;
        end else if (pend_vld) begin
          state_nxt = SHIFT;
          load_new  = 1'b1;
          load_val  = pend_level;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_sr;
    for (int k = 0; k < NUM_DIGITS - 1; k++)
      if (bcd_sr[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
    dd = {bcd_adj, bin_sr} << 1;
  end

  always_comb begin
    seen = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) commit_disp[k] = 8'h00;
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      if (bcd_sr[4*k +: 4] != 4'd0) seen = 1'b1;
      commit_disp[k] = (seen || k == 0) ? dec_glyph(bcd_sr[4*k +: 4]) : 8'h00;
    end
    commit_disp[NUM_DIGITS-1] = tier_glyph(conv_level);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      shift_cnt  <= '0;
      conv_level <= '0;
      pend_level <= '0;
      pend_vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_new) begin
        bin_sr     <= load_val;
        conv_level <= load_val;
        bcd_sr     <= '0;
        shift_cnt  <= '0;
      end else if (state == SHIFT) begin
        bcd_sr    <= dd[BCD_W+LEVEL_W-1:LEVEL_W];
        bin_sr    <= dd[LEVEL_W-1:0];
        shift_cnt <= shift_cnt + CW'(1);
      end
      if (state == COMMIT && (bus.level_valid || pend_vld)) begin
        pend_vld <= 1'b0;
      end else if (state != IDLE && bus.level_valid) begin
        pend_vld   <= 1'b1;
        pend_level <= bus.level;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= 8'h00;
      disp[0]            <= 8'h3F;
      disp[NUM_DIGITS-1] <= 8'h0B;
    end else if (state == COMMIT) begin
      for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= commit_disp[k];
    end
  end

  assign bus.busy = (state != IDLE);
  assign tick     = (presc == PW'(CLK_DIV - 1));

`ifdef EXT_SEG_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_FRAMES + 1);
  logic [BW-1:0]      blink_cnt;
  logic               blank_frame, frame_start;
  logic [LEVEL_W-1:0] disp_level;

  // Remaining-frame count starts even, so even counts are the blank half of each pair.
  assign frame_start = tick && (scan_idx == '0);
  assign blank_now   = frame_start ? (blink_cnt != '0 && !blink_cnt[0]) : blank_frame;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blank_frame <= 1'b0;
      disp_level  <= '0;
    end else begin
      if (frame_start) blank_frame <= blank_now;
      if (state == COMMIT) disp_level <= conv_level;
      if (state == COMMIT && conv_level != disp_level)
        blink_cnt <= BW'(2 * BLINK_FRAMES);
      else if (frame_start && blink_cnt != '0)
        blink_cnt <= blink_cnt - BW'(1);
    end
  end
`else
  // Blanking tied off; BLINK_FRAMES only matters when blinking is built in.
  assign blank_now = (BLINK_FRAMES < 0);
`endif

  // scan_idx names the digit driven at the coming tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc         <= '0;
      scan_idx      <= '0;
      bus.seg_bits  <= 8'h00;
      bus.digit_sel <= '1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        if (blank_now) begin
          bus.seg_bits  <= 8'h00;
          bus.digit_sel <= '1;
        end else begin
          bus.seg_bits  <= disp[scan_idx];
          bus.digit_sel <= ~(NUM_DIGITS'(1) << scan_idx);
        end
      end
    end
  end

endmodule
